// File: rtl/vector_player.sv
// Plays a table of {a,b,c} stimulus vectors, holding each for DWELL cycles,
// and checks the unit-under-test response y against EXP_Y at the end of each dwell.
module vector_player #(
    parameter int                   NUM_VEC = 4,
    parameter int                   DWELL   = 10,
    parameter logic [3*NUM_VEC-1:0] VECTORS = {3'b111, 3'b110, 3'b101, 3'b000},
    parameter logic [NUM_VEC-1:0]   EXP_Y   = 4'b0000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          a,
    output logic                                          b,
    output logic                                          c,
    input  logic                                          y,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          pass,
    output logic [$clog2(NUM_VEC+1)-1:0]                  err_cnt,
    output logic [((NUM_VEC > 1) ? $clog2(NUM_VEC) : 1)-1:0] fail_idx
);

    localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int EW = $clog2(NUM_VEC + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_VEC - 1);
    localparam logic [7:0]    CNT_LAST = 8'(DWELL - 1);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic [IW-1:0] fail_idx_q, fail_idx_d;
    logic          pass_q, pass_d;
    logic [2:0]    vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            fail_idx_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            fail_idx_q <= fail_idx_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;
        fail_idx_d = fail_idx_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    cnt_d      = '0;
                    err_cnt_d  = '0;
                    fail_idx_d = '0;
                    pass_d     = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    if (y != EXP_Y[idx_q]) begin
                        err_cnt_d = err_cnt_q + ERR_ONE;
                        if (err_cnt_q == '0) fail_idx_d = idx_q;
                    end
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_ONE;
                        cnt_d = '0;
                    end else begin
                        state_d = DONE;
                        // pass must include the mismatch from this final sample
                        pass_d  = (err_cnt_d == '0);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so start has no combinational path to them.
    always_comb begin
        vec = '0;
        if (state_q == RUN) vec = VECTORS[32'(idx_q)*3 +: 3];
    end

    assign {a, b, c} = vec;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_idx  = fail_idx_q;

endmodule
